// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising XNOR-LFSR stream checker with lock tracking and a saturating error count.
module lfsr_checker #(
  parameter int NUM_BITS   = 16,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Data_DV,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear,
  output logic                o_Lock,
  output logic                o_Err,
  output logic                o_Illegal,
  output logic [ERR_W-1:0]    o_Err_Count
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  // XAPP052 XNOR taps; tap k maps to mask bit k-1
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [31:0]         TAP_ALL = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS    = TAP_ALL[NUM_BITS-1:0];
  localparam logic [7:0]          LOCK_C  = 8'(LOCK_COUNT);
  localparam logic [7:0]          LOSS_C  = 8'(LOSS_COUNT);

  function automatic logic [NUM_BITS-1:0] nxt(input logic [NUM_BITS-1:0] x);
    return {x[NUM_BITS-2:0], ~^(x & TAPS)};
  endfunction

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] exp_q, exp_d;
  logic [7:0]          good_q, good_d, bad_q, bad_d;
  logic                lock_q, lock_d, err_q, err_d, ill_q, ill_d;
  logic [ERR_W-1:0]    cnt_q, cnt_d;
  logic                ones, hit, inc;
  logic [7:0]          good_inc, bad_inc;

  assign ones     = &i_Data;
  assign hit      = i_Data == exp_q;
  assign good_inc = good_q + 8'd1;
  assign bad_inc  = bad_q + 8'd1;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    ill_d   = 1'b0;
    inc     = 1'b0;
    if (i_Data_DV)
      case (state_q)
        HUNT: begin
          ill_d   = ones;
          exp_d   = ones ? exp_q : nxt(i_Data);
          good_d  = ones ? good_q : 8'd0;
          state_d = ones ? HUNT : VERIFY;
        end
        VERIFY: begin
          // a miss re-seeds from the received word rather than flywheeling
          exp_d   = hit ? nxt(exp_q) : ones ? exp_q : nxt(i_Data);
          good_d  = hit ? good_inc : 8'd0;
          bad_d   = 8'd0;
          state_d = hit ? (good_inc == LOCK_C ? LOCKED : VERIFY) : ones ? HUNT : VERIFY;
        end
        default: begin
          exp_d   = nxt(exp_q);
          err_d   = !hit;
          inc     = !hit;
          bad_d   = hit ? 8'd0 : bad_inc;
          state_d = (!hit && bad_inc == LOSS_C) ? HUNT : LOCKED;
        end
      endcase
    cnt_d  = i_Clear ? '0 : (inc && !(&cnt_q)) ? cnt_q + ERR_W'(1) : cnt_q;
    lock_d = state_d == LOCKED;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state_q <= HUNT;
      exp_q   <= '0;
      good_q  <= 8'd0;
      bad_q   <= 8'd0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end

  assign o_Lock      = lock_q;
  assign o_Err       = err_q;
  assign o_Illegal   = ill_q;
  assign o_Err_Count = cnt_q;
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the LFSR pattern generator. It consumes a stream of NUM_BITS-wide words produced by an LFSR using the same XNOR feedback table (XAPP052 taps, state bits numbered N..1, new bit shifted into bit 1). It self-synchronises to the stream, declares lock, then flywheels and counts mismatches. It is used at the far end of DDR3/video test paths to qualify memory or link integrity.

## Interface
- NUM_BITS, 16, word/LFSR width, legal 3..32; taps identical to the generator table.
- LOCK_COUNT, 8, consecutive matching words needed to declare lock (1..255).
- LOSS_COUNT, 4, consecutive mismatches while locked that drop lock (1..255).
- ERR_W, 16, width of the saturating error counter.
- i_Clk  in  1  single clock, all logic rising-edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Data_DV  in  1  i_Data valid this cycle.
- i_Data  in  NUM_BITS  received LFSR word, bit NUM_BITS-1 = LFSR bit N.
- i_Clear  in  1  synchronous clear of o_Err_Count.
- o_Lock  out  1  checker locked.
- o_Err  out  1  one-cycle pulse: mismatch on a word received while locked.
- o_Illegal  out  1  one-cycle pulse: all-ones word received in HUNT.
- o_Err_Count  out  ERR_W  saturating mismatch count.

## Operation
- next(x) = {x[N-1:1], xnor of tap bits of x}; all-ones is the XNOR lockup state and never occurs in a valid stream.
- Cycles with i_Data_DV=0 change no state except i_Clear handling.
- States: HUNT, VERIFY, LOCKED; reset state HUNT.
- HUNT, DV word w: if w is all-ones, pulse o_Illegal and stay in HUNT. Otherwise set expected = next(w), set good_cnt = 0, and go to VERIFY.
- VERIFY, DV word w: if w == expected, set good_cnt+1 and expected = next(expected); when the incremented good_cnt equals LOCK_COUNT, go to LOCKED. On mismatch, re-seed with expected = next(w) and good_cnt = 0, and stay in VERIFY; an all-ones w sends the checker to HUNT instead. VERIFY mismatches are not counted as errors.
- LOCKED, DV word w:
  - On match, expected = next(expected) and bad_cnt = 0.
  - On mismatch, pulse o_Err, increment o_Err_Count (saturating at 2^ERR_W-1), bad_cnt+1, and expected = next(expected). This is flywheel behaviour: the checker does not re-seed.
  - When the incremented bad_cnt equals LOSS_COUNT, go to HUNT.
- o_Lock = (state == LOCKED), registered.
- i_Clear: o_Err_Count becomes 0 next cycle. Clear has priority over a simultaneous increment, so that error is not counted; o_Err still pulses.
- o_Err_Count is not cleared by lock loss; only reset or i_Clear clears it.

## Timing
- Reset values: o_Lock=0, o_Err=0, o_Illegal=0, o_Err_Count=0, state HUNT, expected=0, good_cnt=0, bad_cnt=0. Reset may assert mid-stream; all of these values apply immediately (asynchronous).
- All outputs are registered, with 1-cycle latency from the DV word that causes them.
- o_Lock rises the cycle after the LOCK_COUNT-th matching word. It therefore needs LOCK_COUNT+1 DV words minimum from HUNT.
- o_Lock falls the cycle after the LOSS_COUNT-th consecutive mismatch. That same word also pulses o_Err.
- Back-to-back DV words are accepted every cycle with no stall. Gaps in DV are transparent: the expected value advances only on DV.
- good_cnt and bad_cnt are 8 bits wide.

## Test plan
All tests use NUM_BITS=4 (taps 4,3), whose sequence from 0 is 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0…; LOCK_COUNT=4, LOSS_COUNT=3, ERR_W=4 unless stated.
- Lock acquisition: feed 0,1,3,7,E on consecutive cycles -> o_Lock=1 the cycle after E; o_Err never pulses; o_Err_Count=0.
- Single error with flywheel: after lock, feed D,5(instead of B),6,C -> one o_Err pulse, 1 cycle after the 5; o_Err_Count=1; o_Lock stays 1; 6 and C match.
- Loss of lock: after lock, feed three consecutive wrong words F,F,F -> o_Err pulses 3 times; o_Err_Count=3; o_Lock=0 the cycle after the third; a clean restart 2,5,A,4,8 then re-locks.
- Illegal/VERIFY re-seed: in HUNT feed F -> o_Illegal pulse, stays unlocked. Then feed 1,3,9(bad),2,5,A,4 -> no o_Err pulses, since the checker re-seeds at 9; o_Lock=1 after 4.
- Saturation and clear: ERR_W=2, locked, 5 mismatches interleaved with matches -> o_Err_Count stops at 3. Assert i_Clear in the same cycle as a mismatch -> count=0 and o_Err pulses.
- Async reset: drop i_Rst_n mid-lock, between clock edges -> all outputs 0 immediately; after release, the checker requires a full re-acquisition.
